// File: rtl/top_mac_st.sv
// top_mac_st: two-stage signed x unsigned multiply-accumulate with 1/2/4-lane precision modes.
// Define TOP_MAC_ST_SATURATE_EN to clamp the accumulator instead of wrapping it.
module top_mac_st #(
   parameter int unsigned W_WIDTH         = 8,
   parameter int unsigned A_WIDTH         = 8,
   parameter int unsigned PLUS_WIDTH      = 4,
   parameter int unsigned CONFIG_AW_WIDTH = 1,
   localparam int unsigned Z_WIDTH        = W_WIDTH + A_WIDTH + PLUS_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       accu_rst,
   input  logic [CONFIG_AW_WIDTH-1:0] config_aw,
   input  logic [W_WIDTH-1:0]         w,
   input  logic [A_WIDTH-1:0]         a,
   output logic [Z_WIDTH-1:0]         z
);

   localparam int unsigned B1  = W_WIDTH;
   localparam int unsigned B2  = W_WIDTH / 2;
   localparam int unsigned B4  = W_WIDTH / 4;
   localparam int unsigned PW1 = 2 * B1 + 1;
   localparam int unsigned PW2 = 2 * B2 + 1;
   localparam int unsigned PW4 = 2 * B4 + 1;

   logic [W_WIDTH-1:0]         w_q;
   logic [A_WIDTH-1:0]         a_q;
   logic                       accu_rst_q;
   logic [CONFIG_AW_WIDTH-1:0] config_aw_q;
   logic signed [Z_WIDTH-1:0]  acc_q, acc_d;

   logic signed [PW1-1:0]     prod_one;
   logic signed [PW2-1:0]     prod_two;
   logic signed [PW4-1:0]     prod_four;
   logic signed [Z_WIDTH-1:0] p_one, p_two, p_four, p;
   logic signed [Z_WIDTH-1:0] acc_sum;
   logic [1:0]                cfg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_q         <= '0;
         a_q         <= '0;
         accu_rst_q  <= 1'b0;
         config_aw_q <= '0;
         acc_q       <= '0;
      end else begin
         w_q         <= w;
         a_q         <= a;
         accu_rst_q  <= accu_rst;
         config_aw_q <= config_aw;
         acc_q       <= acc_d;
      end
   end

   // Activations get a zero MSB so the signed multiply treats them as unsigned.
   always_comb begin
      prod_one = PW1'($signed(w_q)) * PW1'($signed({1'b0, a_q}));
      p_one    = Z_WIDTH'(prod_one);

      prod_two = '0;
      p_two    = '0;
      for (int i = 0; i < 2; i++) begin
         prod_two = PW2'($signed(w_q[i*B2 +: B2])) * PW2'($signed({1'b0, a_q[i*B2 +: B2]}));
         p_two    = p_two + Z_WIDTH'(prod_two);
      end

      prod_four = '0;
      p_four    = '0;
      for (int i = 0; i < 4; i++) begin
         prod_four = PW4'($signed(w_q[i*B4 +: B4])) * PW4'($signed({1'b0, a_q[i*B4 +: B4]}));
         p_four    = p_four + Z_WIDTH'(prod_four);
      end

      cfg = 2'(config_aw_q);
      case (cfg)
         2'd0:    p = p_one;
         2'd3:    p = p_four;
         default: p = p_two;
      endcase
   end

`ifdef TOP_MAC_ST_SATURATE_EN
   localparam int unsigned ZW1 = Z_WIDTH + 1;
   logic signed [ZW1-1:0] sum_wide;

   // One extra bit detects overflow; differing top bits mean the result left the range.
   always_comb begin
      sum_wide = ZW1'(acc_q) + ZW1'(p);
      if (sum_wide[Z_WIDTH] != sum_wide[Z_WIDTH-1]) begin
         acc_sum = sum_wide[Z_WIDTH] ? {1'b1, {(Z_WIDTH-1){1'b0}}}
                                     : {1'b0, {(Z_WIDTH-1){1'b1}}};
      end else begin
         acc_sum = sum_wide[Z_WIDTH-1:0];
      end
   end
`else
   assign acc_sum = acc_q + p;
`endif

   always_comb begin
      acc_d = accu_rst_q ? p : acc_sum;
   end

   assign z = acc_q;

endmodule

// File: tb/tb_top_mac_st.sv
// Self-checking bench for top_mac_st: directed scenarios plus a random run against a
// transaction-level model. Two instances cover CONFIG_AW_WIDTH of 1 and 2.
module tb_top_mac_st;

   localparam longint ZMOD = longint'(1) << 20;
   localparam longint ZMAX = (longint'(1) << 19) - 1;
   localparam longint ZMIN = -(longint'(1) << 19);

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        accu_rst = 1'b0;
   logic [0:0]  cfg1 = '0;
   logic [1:0]  cfg2 = '0;
   logic [7:0]  w = '0;
   logic [7:0]  a = '0;
   logic [19:0] z1, z2;

   int checks = 0;
   int failures = 0;

   longint acc1_m = 0;
   longint acc2_m = 0;

   always #5 clk = ~clk;

   top_mac_st #(.CONFIG_AW_WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .accu_rst(accu_rst), .config_aw(cfg1), .w(w), .a(a), .z(z1)
   );

   top_mac_st #(.CONFIG_AW_WIDTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .accu_rst(accu_rst), .config_aw(cfg2), .w(w), .a(a), .z(z2)
   );

   function automatic int lanes_of(input int cfg);
      if (cfg == 0) return 1;
      if (cfg == 3) return 4;
      return 2;
   endfunction

   // Sum over lanes of signed(w_i) * unsigned(a_i).
   function automatic longint p_model(input logic [7:0] wv, input logic [7:0] av, input int lanes);
      int     b = 8 / lanes;
      longint mask = (longint'(1) << b) - 1;
      longint s = 0;
      for (int i = 0; i < lanes; i++) begin
         longint wi = (longint'(wv) >> (i * b)) & mask;
         longint ai = (longint'(av) >> (i * b)) & mask;
         if (wi >= (longint'(1) << (b - 1))) wi = wi - (longint'(1) << b);
         s = s + wi * ai;
      end
      return s;
   endfunction

   function automatic longint acc_next(input longint acc, input longint p, input logic ar);
      longint s = ar ? p : acc + p;
`ifdef TOP_MAC_ST_SATURATE_EN
      if (s > ZMAX) s = ZMAX;
      if (s < ZMIN) s = ZMIN;
`else
      s = s % ZMOD;
      if (s < 0) s = s + ZMOD;
      if (s > ZMAX) s = s - ZMOD;
`endif
      return s;
   endfunction

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one operand set for one edge; z then reflects the previous operand set.
   task automatic step(input logic [7:0] wv, input logic [7:0] av, input logic ar,
                       input logic [0:0] c1, input logic [1:0] c2);
      longint n1, n2;
      w = wv; a = av; accu_rst = ar; cfg1 = c1; cfg2 = c2;
      n1 = acc_next(acc1_m, p_model(wv, av, lanes_of(int'(c1))), ar);
      n2 = acc_next(acc2_m, p_model(wv, av, lanes_of(int'(c2))), ar);
      @(posedge clk);
      #1;
      check("z1_stream", z1, acc1_m[19:0]);
      check("z2_stream", z2, acc2_m[19:0]);
      acc1_m = n1;
      acc2_m = n2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint p_mark1, p_mark2;
      logic [19:0] exp_wrap;
      int mark;

      // Reset state.
      #7;
      check("reset_z1", z1, 20'h0);
      check("reset_z2", z2, 20'h0);
      #6 rst = 1'b1;
      acc1_m = 0; acc2_m = 0;

      // Full-width -1 * 255.
      step(8'hFF, 8'hFF, 1'b1, 1'b0, 2'd0);
      step(8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
      check("neg255", z1, 20'hFFF01);

      // Two-lane mode: 11 per cycle.
      step(8'h7F, 8'h23, 1'b1, 1'b1, 2'd1);
      for (int i = 0; i < 4; i++) step(8'h7F, 8'h23, 1'b0, 1'b1, 2'd2);
      check("two_lane_44", z1, 20'd44);
      check("two_lane_cfg2_44", z2, 20'd44);

      // Four-lane mode: 12 per cycle on the wide-config instance.
      step(8'h55, 8'hFF, 1'b1, 1'b1, 2'd3);
      for (int i = 0; i < 3; i++) step(8'h55, 8'hFF, 1'b0, 1'b1, 2'd3);
      check("four_lane_36", z2, 20'd36);

      // Accumulator overflow: 17 x (-128 * 255).
      step(8'h80, 8'hFF, 1'b1, 1'b0, 2'd0);
      for (int i = 0; i < 16; i++) step(8'h80, 8'hFF, 1'b0, 1'b0, 2'd0);
      step(8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
`ifdef TOP_MAC_ST_SATURATE_EN
      exp_wrap = 20'h80000;
`else
      exp_wrap = 20'd493696;
`endif
      check("overflow17", z1, exp_wrap);

      // Asynchronous reset between edges mid-accumulation.
      step(8'h12, 8'h34, 1'b1, 1'b1, 2'd1);
      step(8'h12, 8'h34, 1'b0, 1'b1, 2'd1);
      step(8'h12, 8'h34, 1'b0, 1'b1, 2'd1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_z1", z1, 20'h0);
      check("async_rst_z2", z2, 20'h0);
      @(posedge clk);
      #1;
      check("rst_hold_z1", z1, 20'h0);
      #2 rst = 1'b1;
      acc1_m = 0; acc2_m = 0;
      step(8'h12, 8'h34, 1'b0, 1'b1, 2'd1);
      step(8'h12, 8'h34, 1'b0, 1'b1, 2'd1);
      step(8'h12, 8'h34, 1'b0, 1'b1, 2'd1);

      // Random 50-operation run with a forced restart at op 25.
      mark = 25;
      p_mark1 = 0; p_mark2 = 0;
      for (int i = 0; i < 50; i++) begin
         logic [7:0] rw, ra;
         logic       rar;
         logic [0:0] rc1;
         logic [1:0] rc2;
         rw  = 8'($urandom);
         ra  = 8'($urandom);
         rc1 = 1'($urandom);
         rc2 = 2'($urandom);
         rar = (i == 0) || (i == mark) || ($urandom_range(0, 9) == 0);
         if (i == mark) begin
            p_mark1 = p_model(rw, ra, lanes_of(int'(rc1)));
            p_mark2 = p_model(rw, ra, lanes_of(int'(rc2)));
         end
         step(rw, ra, rar, rc1, rc2);
         if (i == mark + 1) begin
            check("restart_z1", z1, p_mark1[19:0]);
            check("restart_z2", z2, p_mark2[19:0]);
         end
      end
      step(8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
      step(8'h00, 8'h00, 1'b1, 1'b0, 2'd0);
      step(8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
      check("zero_restart", z1, 20'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
